pipe_hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the five-stage RV32I pipeline. It produces the enable/flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard types:
- load-use data hazards, with a one-bubble stall;
- taken branches and jumps, with a two-stage flush;
- multi-cycle data-memory accesses, with a full freeze plus a timeout.

It sits beside the pipeline registers, driven by decode/execute/memory-stage status.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM states, NOP encoding, register-index width.
// Constants only; no logic, no latency, no flow control.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a load in EX.
// Purely combinational (0 cycles); no flow control of its own.
module pipe_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    output logic                 lu_hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign lu_hazard = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stall, branch flush, memory freeze with timeout.
// Control outputs are Mealy (0-cycle latency); state moves on the next edge; memory freeze stalls all stages.
// Optional saturating perf counters when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_br_taken,
    input  logic                 mem_req,
    input  logic                 dmem_valid,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_bubble,
    output logic                 mem_err,
    output logic                 busy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     perf_stall_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt,
    output logic [CNT_W-1:0]     perf_memwait_cnt
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_t  state, state_nxt;
    logic [7:0] wait_cnt;
    logic       lu_hazard;
    logic       frozen;
    logic       timeout;
    logic       stall_cyc;
    logic       flush_cyc;

    pipe_hazard_detect u_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hazard   (lu_hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN)
                wait_cnt <= '0;
            else if (!dmem_valid)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_err       = 1'b0;
        busy          = (state == MEM_WAIT);
        state_nxt     = state;
        stall_cyc     = 1'b0;
        flush_cyc     = 1'b0;

        timeout = (state == MEM_WAIT) && !dmem_valid && (wait_cnt == WAIT_LAST);
        frozen  = !dmem_valid && ((state == RUN && mem_req) || (state == MEM_WAIT && !timeout));

        if (frozen) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_nxt     = MEM_WAIT;
        end else begin
            // Release (data or timeout) re-evaluates the hazards still held in the frozen stages.
            if (timeout) begin
                mem_err       = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            state_nxt = RUN;
            if (ex_br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_cyc   = 1'b1;
            end else if (lu_hazard) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                stall_cyc   = 1'b1;
            end
        end

        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
            mem_err       = 1'b0;
            busy          = 1'b0;
            state_nxt     = RUN;
            frozen        = 1'b0;
            stall_cyc     = 1'b0;
            flush_cyc     = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt   <= '0;
            perf_flush_cnt   <= '0;
            perf_memwait_cnt <= '0;
        end else begin
            if (stall_cyc && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (flush_cyc && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            if (frozen && perf_memwait_cnt != '1)
                perf_memwait_cnt <= perf_memwait_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RUN-state vector table plus multi-cycle memory/reset sequences.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    // Output bundle order: pc,if_id,id_ex,ex_mem,mem_wb enables | if_id_flush,id_ex_flush | bubble | err | busy
    localparam logic [9:0] O_DEF   = 10'b11111_00_0_0_0;
    localparam logic [9:0] O_RST   = 10'b00000_11_1_0_0;
    localparam logic [9:0] O_LU    = 10'b00111_01_0_0_0;
    localparam logic [9:0] O_BR    = 10'b11111_11_0_0_0;
    localparam logic [9:0] O_FRZ   = 10'b00001_00_1_0_0;
    localparam logic [9:0] O_FRZ_W = 10'b00001_00_1_0_1;
    localparam logic [9:0] O_REL   = 10'b11111_00_0_0_1;
    localparam logic [9:0] O_TMO   = 10'b11111_00_1_1_1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, dmem_valid;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, busy;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

    logic [9:0] outs;
    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, busy};

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_br_taken   (ex_br_taken),
        .mem_req       (mem_req),
        .dmem_valid    (dmem_valid),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_err       (mem_err),
        .busy          (busy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_flush_cnt   (perf_flush_cnt),
        .perf_memwait_cnt (perf_memwait_cnt)
`endif
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, mq, dv;
        logic [9:0] exp;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] rd, input logic mr,
                                input logic br, input logic mq, input logic dv, input logic [9:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.br = br; v.mq = mq; v.dv = dv; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_rd = v.rd; ex_mem_read = v.mr; ex_br_taken = v.br;
        mem_req = v.mq; dmem_valid = v.dv;
    endtask

    task automatic idle();
        drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF));
    endtask

    // Sample on the falling edge, then step to just after the next rising edge.
    task automatic chk(input logic [9:0] exp, input string nm);
        logic [9:0] act;
        @(negedge clk);
        act = outs;
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic chk_cnt(input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp, input string nm);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
`endif

    logic [CNT_W-1:0] s0, f0, m0;

    initial begin
        s0 = '0; f0 = '0; m0 = '0;
        //            rs1    rs2    u1    u2    rd     mr    br    mq    dv    expected
        vt[0] = mk(5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, O_DEF);
        vt[1] = mk(5'd1,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        vt[2] = mk(5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_DEF);
        vt[3] = mk(5'd9,  5'd2,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        vt[4] = mk(5'd9,  5'd2,  1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, O_DEF);
        vt[5] = mk(5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, O_DEF);
        vt[6] = mk(5'd4,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, O_BR);
        vt[7] = mk(5'd4,  5'd5,  1'b1, 1'b1, 5'd6,  1'b0, 1'b1, 1'b0, 1'b0, O_BR);
        vt[8] = mk(5'd4,  5'd5,  1'b1, 1'b1, 5'd6,  1'b0, 1'b0, 1'b1, 1'b1, O_DEF);
        vt[9] = mk(5'd31, 5'd1,  1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, O_LU);

        rst = 1'b1;
        idle();
        chk(O_RST, "reset_outputs");
        rst = 1'b0;
`ifdef PIPE_PERF_CNT_EN
        chk_cnt(perf_stall_cnt, '0, "reset_stall_cnt");
        chk_cnt(perf_flush_cnt, '0, "reset_flush_cnt");
        chk_cnt(perf_memwait_cnt, '0, "reset_memwait_cnt");
`endif

        for (int i = 0; i < 10; i++) begin
            drive(vt[i]);
            chk(vt[i].exp, $sformatf("vec%0d", i));
        end

        // Load-use: one stall cycle, then the load has moved on.
`ifdef PIPE_PERF_CNT_EN
        s0 = perf_stall_cnt; f0 = perf_flush_cnt; m0 = perf_memwait_cnt;
`endif
        drive(vt[1]);
        chk(O_LU, "lu_stall");
        idle();
        chk(O_DEF, "lu_after");
`ifdef PIPE_PERF_CNT_EN
        chk_cnt(perf_stall_cnt - s0, 1, "lu_stall_cnt");
        f0 = perf_flush_cnt; s0 = perf_stall_cnt;
`endif
        // Branch with load-use in the same cycle.
        drive(vt[6]);
        chk(O_BR, "br_lu");
        idle();
`ifdef PIPE_PERF_CNT_EN
        chk_cnt(perf_flush_cnt - f0, 1, "br_flush_cnt");
        chk_cnt(perf_stall_cnt - s0, 0, "br_no_stall_cnt");
        m0 = perf_memwait_cnt;
`endif

        // Memory wait, data on cycle 4; a branch during the freeze is ignored.
        mem_req = 1'b1;
        chk(O_FRZ, "mw_c1");
        chk(O_FRZ_W, "mw_c2");
        ex_br_taken = 1'b1;
        chk(O_FRZ_W, "mw_c3_br_ignored");
        ex_br_taken = 1'b0;
        dmem_valid = 1'b1;
        chk(O_REL, "mw_c4_release");
        idle();
        chk(O_DEF, "mw_c5_run");
`ifdef PIPE_PERF_CNT_EN
        chk_cnt(perf_memwait_cnt - m0, 3, "mw_memwait_cnt");
`endif

        // Timeout: TO frozen cycles, then abandon with mem_err.
        mem_req = 1'b1;
        chk(O_FRZ, "to_c1");
        for (int i = 2; i <= TO; i++) chk(O_FRZ_W, $sformatf("to_c%0d", i));
        chk(O_TMO, "to_release");
        idle();
        chk(O_DEF, "to_after");

        // Data arriving on the timeout cycle wins.
        mem_req = 1'b1;
        chk(O_FRZ, "tv_c1");
        for (int i = 2; i <= TO; i++) chk(O_FRZ_W, $sformatf("tv_c%0d", i));
        dmem_valid = 1'b1;
        chk(O_REL, "tv_release_no_err");
        idle();
        chk(O_DEF, "tv_after");

        // Reset mid-wait, then a fresh access must time out after the full count.
        mem_req = 1'b1;
        chk(O_FRZ, "rw_c1");
        chk(O_FRZ_W, "rw_c2");
        rst = 1'b1;
        chk(O_RST, "rw_reset");
        rst = 1'b0;
        idle();
        chk(O_DEF, "rw_after_reset");
        mem_req = 1'b1;
        chk(O_FRZ, "rw2_c1");
        for (int i = 2; i <= TO; i++) chk(O_FRZ_W, $sformatf("rw2_c%0d", i));
        chk(O_TMO, "rw2_timeout");
        idle();
        chk(O_DEF, "rw2_after");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
